// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage: FSM state encoding,
// EX/MEM latch layout, default access timeout and the abort data pattern.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam int unsigned TIMEOUT_DEFAULT = 32'd255;
  localparam logic [31:0] ERR_DATA        = 32'hDEADBEEF;

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic        mem_to_reg;
    logic        mem_read;
    logic        mem_write;
    logic [4:0]  wr_reg;
    logic [31:0] alu_result;
    logic [31:0] wr_data;
  } ex_mem_t;

  // A bubble never touches memory, whatever its control bits say.
  function automatic logic is_mem_op(input ex_mem_t e);
    return e.valid & (e.mem_read | e.mem_write);
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/response port of the MEM stage.
// The stage is the master; the memory (or its model) is the slave.
interface mem_stage_if;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_ack,
    output mem_rdata
  );

endinterface

// File: rtl/mem_access_fsm.sv
// IDLE/ACCESS/DONE sequencer for one data-memory access, with an ACCESS-cycle
// counter that aborts the access after TIMEOUT_CYCLES cycles without ack.
module mem_access_fsm
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic   i_clk,
  input  logic   i_rst,
  input  logic   i_new_memop,
  input  logic   i_ack,
  output state_e o_state,
  output logic   o_req,
  output logic   o_stall,
  output logic   o_ack_take,
  output logic   o_abort
);

  localparam logic [7:0] TMO = 8'(TIMEOUT_CYCLES);

  state_e     r_state;
  state_e     w_state_next;
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_next;
  logic [7:0] w_cnt_inc;

  // State register and ACCESS-cycle counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next-state logic; an ack on the final allowed cycle still wins over abort.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_cnt_inc    = r_cnt + 8'd1;
    o_ack_take   = 1'b0;
    o_abort      = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (i_new_memop) begin
          w_state_next = ST_ACCESS;
          w_cnt_next   = 8'd0;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        w_cnt_next = w_cnt_inc;
        if (i_ack) begin
          o_ack_take   = 1'b1;
          w_state_next = ST_DONE;
        end else if (w_cnt_inc >= TMO) begin
          o_abort      = 1'b1;
          w_state_next = ST_DONE;
        end else begin
          w_state_next = ST_ACCESS;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = 8'd0;
      end
    endcase
  end

  assign o_state = r_state;
  assign o_req   = (r_state == ST_ACCESS);
  assign o_stall = (r_state == ST_ACCESS);

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: EX/MEM latch, data-memory access sequencing with timeout
// abort, and the outputs feeding the MEM/WB register.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic         Clk,
  input  logic         reset,
  input  logic [31:0]  ALUResult_EX,
  input  logic [31:0]  WriteData_EX,
  input  logic [4:0]   WriteRegister_EX,
  input  logic         RegWrite_EX,
  input  logic         MemToReg_EX,
  input  logic         MemRead_EX,
  input  logic         MemWrite_EX,
  input  logic         Valid_EX,
  input  logic         Flush,
  output logic         Stall_MEM,
  mem_stage_if.master  mem,
  output logic [31:0]  ALUResult,
  output logic [31:0]  dataMemOut,
  output logic         RegWrite,
  output logic         MemToReg,
  output logic [4:0]   WriteRegister,
  output logic         MemError
);

  ex_mem_t     r_ex_mem;
  ex_mem_t     w_ex_next;
  logic [31:0] r_data;
  logic        r_mem_error;
  logic        r_aborted;

  state_e      w_state;
  logic        w_access;
  logic        w_req;
  logic        w_stall;
  logic        w_ack_take;
  logic        w_abort;
  logic        w_new_memop;
  logic        w_is_read;

  // Flush and invalid EX slots enter the latch as all-zero bubbles.
  always_comb begin
    w_ex_next = '0;
    if (Valid_EX && !Flush) begin
      w_ex_next.valid      = 1'b1;
      w_ex_next.reg_write  = RegWrite_EX;
      w_ex_next.mem_to_reg = MemToReg_EX;
      w_ex_next.mem_read   = MemRead_EX;
      w_ex_next.mem_write  = MemWrite_EX;
      w_ex_next.wr_reg     = WriteRegister_EX;
      w_ex_next.alu_result = ALUResult_EX;
      w_ex_next.wr_data    = WriteData_EX;
    end else begin
      w_ex_next = '0;
    end
  end

  assign w_new_memop = is_mem_op(w_ex_next);

  mem_access_fsm #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_fsm (
    .i_clk       (Clk),
    .i_rst       (reset),
    .i_new_memop (w_new_memop),
    .i_ack       (mem.mem_ack),
    .o_state     (w_state),
    .o_req       (w_req),
    .o_stall     (w_stall),
    .o_ack_take  (w_ack_take),
    .o_abort     (w_abort)
  );

  assign w_access  = (w_state == ST_ACCESS);
  // Write has priority: a slot with both read and write set is a store.
  assign w_is_read = r_ex_mem.mem_read & ~r_ex_mem.mem_write;

  // EX/MEM latch, load data register and sticky error flag.
  always_ff @(posedge Clk) begin
    if (reset) begin
      r_ex_mem    <= '0;
      r_data      <= 32'd0;
      r_mem_error <= 1'b0;
      r_aborted   <= 1'b0;
    end else begin
      if (!w_stall) begin
        r_ex_mem  <= w_ex_next;
        r_aborted <= 1'b0;
      end
      if (w_ack_take && w_is_read) begin
        r_data <= mem.mem_rdata;
      end else if (w_abort) begin
        r_data      <= ERR_DATA;
        r_mem_error <= 1'b1;
        r_aborted   <= 1'b1;
      end
    end
  end

  assign mem.mem_req   = w_req;
  assign mem.mem_we    = w_access & r_ex_mem.mem_write;
  assign mem.mem_addr  = w_access ? r_ex_mem.alu_result : 32'd0;
  assign mem.mem_wdata = w_access ? r_ex_mem.wr_data : 32'd0;

  assign Stall_MEM     = w_stall;
  // MEM/WB sees a bubble while stalled and when an aborted access retires.
  assign RegWrite      = ~w_access & r_ex_mem.reg_write & r_ex_mem.valid & ~r_aborted;
  assign MemToReg      = r_ex_mem.mem_to_reg;
  assign WriteRegister = r_ex_mem.wr_reg;
  assign ALUResult     = r_ex_mem.alu_result;
  assign dataMemOut    = r_data;
  assign MemError      = r_mem_error;

endmodule
